// File: rtl/sid_pkg.sv
// Shared constants, types and the noise LFSR shift for the SID voice scheduler.
package sid_pkg;

  localparam int unsigned ACC_W         = 24;
  localparam int unsigned LFSR_W        = 23;
  localparam int unsigned LFSR_TAP_A    = 17;
  localparam int unsigned LFSR_TAP_B    = 22;
  localparam int unsigned NOISE_CLK_BIT = 19;
  localparam int unsigned FREQ_W        = 16;
  localparam int unsigned VIDX_W        = 3;
  localparam int unsigned MAX_VOICES    = 8;
  localparam int unsigned OSC3_W        = 8;

  typedef struct packed {
    logic test;
    logic sync;
  } voice_ctrl_t;

  typedef logic [VIDX_W-1:0] voice_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } sched_state_t;

  // One noise clock: shift left, feed back tap A xor tap B.
  function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/sid_voice_sched_if.sv
// Register-write / slot-result bus between the decoder, the scheduler and the waveform generators.
interface sid_voice_sched_if;
  import sid_pkg::*;

  logic                clk_en;
  logic                wr_en;
  voice_idx_t          wr_voice;
  logic [FREQ_W-1:0]   wr_freq;
  logic                wr_test;
  logic                wr_sync;
  logic                ovr_clr;
  logic                busy;
  logic                out_valid;
  voice_idx_t          out_voice;
  logic [ACC_W-1:0]    out_acc;
  logic [LFSR_W-1:0]   out_lfsr;
  logic                out_sync;
  logic                overrun;
  logic [OSC3_W-1:0]   osc3_out;

  modport master (
    output clk_en, wr_en, wr_voice, wr_freq, wr_test, wr_sync, ovr_clr,
    input  busy, out_valid, out_voice, out_acc, out_lfsr, out_sync, overrun, osc3_out
  );

  modport slave (
    input  clk_en, wr_en, wr_voice, wr_freq, wr_test, wr_sync, ovr_clr,
    output busy, out_valid, out_voice, out_acc, out_lfsr, out_sync, overrun, osc3_out
  );

endinterface

// File: rtl/sid_acc_step.sv
// Combinational single-voice step: phase accumulate, hard sync, test bit and noise clock.
module sid_acc_step
  import sid_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [FREQ_W-1:0] freq_i,
  input  logic [LFSR_W-1:0] lfsr_i,
  input  voice_ctrl_t       ctrl_i,
  input  logic              src_sync_i,
  output logic [ACC_W-1:0]  acc_next_c_o,
  output logic [LFSR_W-1:0] lfsr_next_c_o,
  output logic              sync_c_o
);

  logic [ACC_W-1:0] sum;

  assign sum = acc_i + ACC_W'(freq_i);

  // Test overrides sync; noise clocks on a 0->1 of the noise bit of the final value.
  always_comb begin
    acc_next_c_o  = sum;
    lfsr_next_c_o = lfsr_i;
    if (ctrl_i.sync && src_sync_i) begin
      acc_next_c_o = '0;
    end
    if (ctrl_i.test) begin
      acc_next_c_o  = '0;
      lfsr_next_c_o = '1;
    end else if (!acc_i[NOISE_CLK_BIT] && acc_next_c_o[NOISE_CLK_BIT]) begin
      lfsr_next_c_o = lfsr_shift(lfsr_i);
    end
  end

  assign sync_c_o = !acc_i[ACC_W-1] && acc_next_c_o[ACC_W-1];

endmodule

// File: rtl/sid_voice_sched.sv
// Sequences NUM_VOICES voices through one shared step datapath per SID tick.
// Optional OSC3 read-back register enabled by SID_OSC3_READ_EN.
module sid_voice_sched
  import sid_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3
) (
  input  logic            clk,
  input  logic            reset,
  sid_voice_sched_if.slave bus
);

  localparam voice_idx_t LAST_IDX = voice_idx_t'(NUM_VOICES - 1);

  sched_state_t          state_q;
  voice_idx_t            idx_q;
  logic [FREQ_W-1:0]     freq_q [MAX_VOICES];
  voice_ctrl_t           ctrl_q [MAX_VOICES];
  logic [ACC_W-1:0]      acc_q  [MAX_VOICES];
  logic [LFSR_W-1:0]     lfsr_q [MAX_VOICES];
  logic [MAX_VOICES-1:0] sync_pend_q;
  logic [MAX_VOICES-1:0] sync_snap_q;

  logic                  busy_q;
  logic                  out_valid_q;
  voice_idx_t            out_voice_q;
  logic [ACC_W-1:0]      out_acc_q;
  logic [LFSR_W-1:0]     out_lfsr_q;
  logic                  out_sync_q;
  logic                  overrun_q;

  voice_idx_t            src_idx;
  logic [ACC_W-1:0]      acc_d;
  logic [LFSR_W-1:0]     lfsr_d;
  logic                  sync_d;
  logic                  wr_ok;

  // Voice 0 syncs from the last voice's edge of the previous tick.
  assign src_idx = (idx_q == '0) ? LAST_IDX : idx_q - voice_idx_t'(1);
  assign wr_ok   = bus.wr_en && (32'(bus.wr_voice) < NUM_VOICES);

  sid_acc_step u_step (
    .acc_i         (acc_q[idx_q]),
    .freq_i        (freq_q[idx_q]),
    .lfsr_i        (lfsr_q[idx_q]),
    .ctrl_i        (ctrl_q[idx_q]),
    .src_sync_i    (sync_snap_q[src_idx]),
    .acc_next_c_o  (acc_d),
    .lfsr_next_c_o (lfsr_d),
    .sync_c_o      (sync_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      freq_q      <= '{default: '0};
      ctrl_q      <= '{default: '0};
      acc_q       <= '{default: '0};
      lfsr_q      <= '{default: '1};
      sync_pend_q <= '0;
      sync_snap_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_voice_q <= '0;
      out_acc_q   <= '0;
      out_lfsr_q  <= '0;
      out_sync_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;

      if (wr_ok) begin
        freq_q[bus.wr_voice] <= bus.wr_freq;
        ctrl_q[bus.wr_voice] <= '{test: bus.wr_test, sync: bus.wr_sync};
      end

      // A tick arriving mid-sequence is dropped; setting beats clearing.
      if (bus.clk_en && busy_q) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.clk_en) begin
            sync_snap_q <= sync_pend_q;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= SLOT;
          end
        end
        SLOT: begin
          acc_q[idx_q]       <= acc_d;
          lfsr_q[idx_q]      <= lfsr_d;
          sync_pend_q[idx_q] <= sync_d;
          out_valid_q        <= 1'b1;
          out_voice_q        <= idx_q;
          out_acc_q          <= acc_d;
          out_lfsr_q         <= lfsr_d;
          out_sync_q         <= sync_d;
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + voice_idx_t'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_voice = out_voice_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_lfsr  = out_lfsr_q;
  assign bus.out_sync  = out_sync_q;
  assign bus.overrun   = overrun_q;

`ifdef SID_OSC3_READ_EN
  logic [OSC3_W-1:0] osc3_q;

  // Upper accumulator byte of voice 2, held for CPU read-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osc3_q <= '0;
    end else if (state_q == SLOT && idx_q == voice_idx_t'(2)) begin
      osc3_q <= acc_d[ACC_W-1 -: OSC3_W];
    end
  end

  assign bus.osc3_out = osc3_q;
`else
  assign bus.osc3_out = '0;
`endif

endmodule

// File: tb/tb_sid_voice_sched.sv
// Directed + randomized bench for sid_voice_sched against an arithmetic reference model.
module tb_sid_voice_sched;
  import sid_pkg::*;

  localparam int unsigned NV = 3;

  logic clk = 1'b0;
  logic reset;

  sid_voice_sched_if bus ();

  sid_voice_sched #(.NUM_VOICES(NV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  int unsigned m_acc [8];
  int unsigned m_lfsr[8];
  int unsigned m_freq[8];
  bit          m_test[8];
  bit          m_sync[8];
  bit          m_pend[8];
  int unsigned m_osc3;
  int unsigned exp_acc [8];
  int unsigned exp_lfsr[8];
  bit          exp_sync[8];
  int unsigned obs_acc [8];
  int unsigned obs_lfsr[8];
  bit          obs_sync[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 8; v++) begin
      m_acc[v]  = 0;
      m_lfsr[v] = 32'h7F_FFFF;
      m_freq[v] = 0;
      m_test[v] = 1'b0;
      m_sync[v] = 1'b0;
      m_pend[v] = 1'b0;
    end
    m_osc3 = 0;
  endtask

  // One SID tick over all voices, using last tick's edges for hard sync.
  task automatic model_tick();
    bit snap[8];
    int unsigned src, nxt, nl;
    snap = m_pend;
    for (int v = 0; v < int'(NV); v++) begin
      src = (v == 0) ? NV - 1 : v - 1;
      nxt = (m_acc[v] + m_freq[v]) & 32'hFF_FFFF;
      nl  = m_lfsr[v];
      if (m_sync[v] && snap[src]) nxt = 0;
      if (m_test[v]) begin
        nxt = 0;
        nl  = 32'h7F_FFFF;
      end else if (((m_acc[v] >> 19) & 1) == 0 && ((nxt >> 19) & 1) == 1) begin
        nl = ((nl << 1) & 32'h7F_FFFF) | (((nl >> 17) ^ (nl >> 22)) & 1);
      end
      exp_sync[v] = (m_acc[v] < 32'h80_0000) && (nxt >= 32'h80_0000);
      exp_acc[v]  = nxt;
      exp_lfsr[v] = nl;
      m_pend[v]   = exp_sync[v];
      m_acc[v]    = nxt;
      m_lfsr[v]   = nl;
    end
    if (NV > 2) m_osc3 = exp_acc[2] >> 16;
  endtask

  function automatic int unsigned osc3_exp();
`ifdef SID_OSC3_READ_EN
    return m_osc3;
`else
    return 0;
`endif
  endfunction

  task automatic wr(input int v, input logic [15:0] f, input bit t, input bit s);
    bus.wr_en    = 1'b1;
    bus.wr_voice = voice_idx_t'(v);
    bus.wr_freq  = f;
    bus.wr_test  = t;
    bus.wr_sync  = s;
    cyc();
    bus.wr_en = 1'b0;
    if (v < int'(NV)) begin
      m_freq[v] = f;
      m_test[v] = t;
      m_sync[v] = s;
    end
  endtask

  task automatic chk_slot(input int k, input int tick);
    chk($sformatf("valid t%0d k%0d", tick, k), bus.out_valid, 1);
    chk($sformatf("voice t%0d k%0d", tick, k), bus.out_voice, k);
    chk($sformatf("acc t%0d v%0d", tick, k), bus.out_acc, exp_acc[k]);
    chk($sformatf("lfsr t%0d v%0d", tick, k), bus.out_lfsr, exp_lfsr[k]);
    chk($sformatf("sync t%0d v%0d", tick, k), bus.out_sync, exp_sync[k]);
    obs_acc[k]  = bus.out_acc;
    obs_lfsr[k] = bus.out_lfsr;
    obs_sync[k] = bus.out_sync;
  endtask

  // Full tick; optional write to voice 0 while voice 0 is being stepped.
  task automatic do_tick(input int tick, input int pad, input bit mw, input logic [15:0] mw_freq);
    model_tick();
    bus.clk_en = 1'b1;
    cyc();
    bus.clk_en = 1'b0;
    chk($sformatf("busy_start t%0d", tick), bus.busy, 1);
    if (mw) begin
      bus.wr_en    = 1'b1;
      bus.wr_voice = '0;
      bus.wr_freq  = mw_freq;
      bus.wr_test  = 1'b0;
      bus.wr_sync  = 1'b0;
      m_freq[0] = mw_freq;
      m_test[0] = 1'b0;
      m_sync[0] = 1'b0;
    end
    cyc();
    bus.wr_en = 1'b0;
    for (int k = 0; k < int'(NV); k++) begin
      chk_slot(k, tick);
      chk($sformatf("busy t%0d k%0d", tick, k), bus.busy, (k <= int'(NV) - 2) ? 1 : 0);
      cyc();
    end
    chk($sformatf("valid_after t%0d", tick), bus.out_valid, 0);
    chk($sformatf("osc3 t%0d", tick), bus.osc3_out, osc3_exp());
    repeat (pad) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    model_reset();
    cyc();
  endtask

  initial begin
    bus.clk_en   = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_voice = '0;
    bus.wr_freq  = '0;
    bus.wr_test  = 1'b0;
    bus.wr_sync  = 1'b0;
    bus.ovr_clr  = 1'b0;
    reset        = 1'b1;
    model_reset();
    cyc();
    cyc();

    chk("rst busy", bus.busy, 0);
    chk("rst valid", bus.out_valid, 0);
    chk("rst voice", bus.out_voice, 0);
    chk("rst acc", bus.out_acc, 0);
    chk("rst lfsr", bus.out_lfsr, 0);
    chk("rst sync", bus.out_sync, 0);
    chk("rst overrun", bus.overrun, 0);
    chk("rst osc3", bus.osc3_out, 0);
    reset = 1'b0;
    cyc();

    // Free run and noise clock on voice 0
    wr(0, 16'h1000, 1'b0, 1'b0);
    for (int t = 1; t <= 2049; t++) begin
      do_tick(t, 3, 1'b0, 16'h0);
      if (t == 127) chk("noise t127 lfsr", obs_lfsr[0], 32'h7F_FFFF);
      if (t == 128) begin
        chk("noise t128 acc", obs_acc[0], 32'h08_0000);
        chk("noise t128 lfsr", obs_lfsr[0], 32'h7F_FFFE);
      end
      if (t == 129) chk("noise t129 lfsr", obs_lfsr[0], 32'h7F_FFFE);
      if (t == 2047) chk("free t2047 sync", obs_sync[0], 0);
      if (t == 2048) begin
        chk("free t2048 acc", obs_acc[0], 32'h80_0000);
        chk("free t2048 sync", obs_sync[0], 1);
      end
      if (t == 2049) chk("free t2049 sync", obs_sync[0], 0);
    end

    // Hard sync enabled on voice 1
    do_reset();
    wr(0, 16'h8000, 1'b0, 1'b0);
    wr(1, 16'h0100, 1'b0, 1'b1);
    for (int t = 1; t <= 257; t++) begin
      do_tick(t, 0, 1'b0, 16'h0);
      if (t == 256) chk("hsync t256 v0 sync", obs_sync[0], 1);
      if (t == 257) chk("hsync t257 v1 acc", obs_acc[1], 0);
    end

    // Same setup without sync
    do_reset();
    wr(0, 16'h8000, 1'b0, 1'b0);
    wr(1, 16'h0100, 1'b0, 1'b0);
    for (int t = 1; t <= 257; t++) begin
      do_tick(t, 0, 1'b0, 16'h0);
      if (t == 257) chk("nosync t257 v1 acc", obs_acc[1], 32'h01_0100);
    end

    // Test bit on voice 2
    wr(2, 16'hFFFF, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) begin
      do_tick(t, 1, 1'b0, 16'h0);
      chk($sformatf("test acc t%0d", t), obs_acc[2], 0);
      chk($sformatf("test lfsr t%0d", t), obs_lfsr[2], 32'h7F_FFFF);
    end
    wr(2, 16'hFFFF, 1'b0, 1'b0);
    do_tick(3, 1, 1'b0, 16'h0);
    chk("test cleared acc", obs_acc[2], 32'h00_FFFF);

    // Ignored writes to out-of-range voices, and a write into the active slot
    wr(5, 16'h1234, 1'b1, 1'b1);
    wr(7, 16'hFFFF, 1'b1, 1'b0);
    do_tick(0, 2, 1'b1, 16'h0040);
    do_tick(1, 2, 1'b0, 16'h0);

    // Overrun: second clk_en two cycles later is dropped; set beats clear
    model_tick();
    bus.clk_en = 1'b1;
    cyc();
    bus.clk_en = 1'b0;
    cyc();
    chk("ovr before", bus.overrun, 0);
    chk_slot(0, -1);
    bus.clk_en  = 1'b1;
    bus.ovr_clr = 1'b1;
    cyc();
    bus.clk_en  = 1'b0;
    bus.ovr_clr = 1'b0;
    chk("ovr set", bus.overrun, 1);
    chk_slot(1, -1);
    cyc();
    chk_slot(2, -1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr no extra valid %0d", i), bus.out_valid, 0);
      chk($sformatf("ovr idle busy %0d", i), bus.busy, 0);
      cyc();
    end
    chk("ovr sticky", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    cyc();
    bus.ovr_clr = 1'b0;
    chk("ovr cleared", bus.overrun, 0);
    do_tick(0, 2, 1'b0, 16'h0);

    // Randomized writes and tick spacing
    for (int t = 0; t < 80; t++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        wr($urandom_range(0, 7), 16'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end
      do_tick(t, $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 16'($urandom));
    end

    // Reset in the middle of a sequence
    bus.clk_en = 1'b1;
    cyc();
    cyc();
    bus.clk_en = 1'b0;
    chk("mid pre overrun", bus.overrun, 1);
    reset = 1'b1;
    #1;
    chk("mid rst busy", bus.busy, 0);
    chk("mid rst valid", bus.out_valid, 0);
    chk("mid rst overrun", bus.overrun, 0);
    cyc();
    reset = 1'b0;
    model_reset();
    cyc();
    do_tick(0, 2, 1'b0, 16'h0);
    for (int v = 0; v < int'(NV); v++) begin
      chk($sformatf("post rst acc v%0d", v), obs_acc[v], 0);
      chk($sformatf("post rst lfsr v%0d", v), obs_lfsr[v], 32'h7F_FFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
